// File: rtl/au_pkg.sv
// Shared definitions for the arithmetic unit and its command issuer:
// widths, op/select codes, error codes, issuer FSM states and saturation helpers.
package au_pkg;

  localparam int W    = 24;
  localparam int FRAC = 14;

  localparam logic [1:0]   OP_DIV     = 2'b11;
  localparam logic [1:0]   YSEL_RECIP = 2'b10;
  localparam logic [W-2:0] SAT_MAG    = {(W-1){1'b1}};

  typedef enum logic [1:0] {
    ERR_OK = 2'b00,
    ERR_DZ = 2'b01,
    ERR_TO = 2'b10
  } au_err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } au_issue_state_e;

  // Reciprocal divide with a zero magnitude divisor; -0 counts as zero.
  function automatic logic is_recip_dz(input logic [1:0] op, input logic [1:0] ysel,
                                       input logic [W-1:0] s);
    return (op == OP_DIV) && (ysel == YSEL_RECIP) && (s[W-2:0] == {(W-1){1'b0}});
  endfunction

  function automatic logic [W-1:0] dz_result(input logic [W-1:0] r, input logic [W-1:0] s);
    return {r[W-1] ^ s[W-1], SAT_MAG};
  endfunction

endpackage

// File: rtl/au_issue_wdog.sv
// WAIT-cycle watchdog for au_issue, only instantiated when AU_ISSUE_TIMEOUT_EN is defined.
// expired is registered and goes high during the TIMEOUT-th enabled cycle after clear.
module au_issue_wdog #(
  parameter int TIMEOUT = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_r;

  // Count enabled cycles; expired looks one count ahead so it is registered yet on time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
      expired <= 1'b0;
    end else if (clear) begin
      count_r <= {CW{1'b0}};
      expired <= 1'b0;
    end else if (en && !expired) begin
      count_r <= count_r + CW'(1);
      expired <= (count_r == CW'(TIMEOUT - 2));
    end else begin
      count_r <= count_r;
      expired <= expired;
    end
  end

endmodule

// File: rtl/au_issue.sv
// Command issuer for the AU start/done handshake with reciprocal divide-by-zero pre-screen.
// Define AU_ISSUE_TIMEOUT_EN to bound WAIT with a watchdog (rsp_err=10 on expiry).
module au_issue
  import au_pkg::*;
#(
  parameter int W       = au_pkg::W,
  parameter int FRAC    = au_pkg::FRAC,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [1:0]      req_ysel,
  input  logic [W-1:0]    req_r,
  input  logic [W-1:0]    req_s,
  input  logic [W-1:0]    req_imm,
  input  logic [TAGW-1:0] req_tag,
  output logic            au_start,
  output logic [W-1:0]    au_r,
  output logic [W-1:0]    au_s,
  output logic [W-1:0]    au_imm,
  output logic [1:0]      au_op_sel,
  output logic [1:0]      au_mul_y_sel,
  input  logic [W-1:0]    au_result,
  input  logic            au_done,
  input  logic            au_busy,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic [TAGW-1:0] rsp_tag,
  output logic [1:0]      rsp_err
);

  au_issue_state_e state_r;
  logic            accept_s;
  logic            dz_s;
  logic            timeout_s;

  assign accept_s = req_valid && req_ready;
  assign dz_s     = is_recip_dz(req_op, req_ysel, req_s);

`ifdef AU_ISSUE_TIMEOUT_EN
  logic wdog_clear_s;
  logic wdog_en_s;

  // ISSUE always precedes WAIT, so clearing there restarts the count on every WAIT entry
  assign wdog_clear_s = (state_r == ISSUE);
  assign wdog_en_s    = (state_r == WAIT);

  au_issue_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wdog_clear_s),
    .en      (wdog_en_s),
    .expired (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Issuer FSM with all handshake, operand and response outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      req_ready    <= 1'b0;
      au_start     <= 1'b0;
      au_r         <= {W{1'b0}};
      au_s         <= {W{1'b0}};
      au_imm       <= {W{1'b0}};
      au_op_sel    <= 2'b00;
      au_mul_y_sel <= 2'b00;
      rsp_valid    <= 1'b0;
      rsp_data     <= {W{1'b0}};
      rsp_tag      <= {TAGW{1'b0}};
      rsp_err      <= ERR_OK;
    end else begin
      au_start <= 1'b0;
      case (state_r)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept_s) begin
            req_ready    <= 1'b0;
            au_r         <= req_r;
            au_s         <= req_s;
            au_imm       <= req_imm;
            au_op_sel    <= req_op;
            au_mul_y_sel <= req_ysel;
            rsp_tag      <= req_tag;
            if (dz_s) begin
              state_r   <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= dz_result(req_r, req_s);
              rsp_err   <= ERR_DZ;
            end else begin
              // Start straight away when the AU is idle at the accept edge
              state_r  <= ISSUE;
              au_start <= !au_busy;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (au_start) begin
            state_r <= WAIT;
          end else if (!au_busy) begin
            au_start <= 1'b1;
          end else begin
            state_r <= ISSUE;
          end
        end
        WAIT: begin
          if (au_done) begin
            state_r   <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= au_result;
            rsp_err   <= ERR_OK;
          end else if (timeout_s) begin
            state_r   <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= {W{1'b0}};
            rsp_err   <= ERR_TO;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r   <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
